instr_fetch: RTL and testbench

//  Fetch stage that drives the PC register and reads its output back. Each cycle it

---
 rtl/instr_fetch_if.sv | 28 ++
 rtl/instr_fetch.sv | 132 +++++++++++++
 tb/tb_instr_fetch.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: PC register loop, instruction-memory read port and decode handshake.
interface instr_fetch_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] pc_in;
  logic [ADDR_W-1:0] pc_next;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              halted;

  modport master (
    input  pc_in, redirect, redirect_addr, imem_rdata, instr_ready,
    output pc_next, imem_req, imem_addr, instr, instr_pc, instr_valid, halted
  );

  modport slave (
    output pc_in, redirect, redirect_addr, imem_rdata, instr_ready,
    input  pc_next, imem_req, imem_addr, instr, instr_pc, instr_valid, halted
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: issues imem reads under a queue-credit rule, buffers returned words
// in a small shift queue for decode, and handles branch redirect and HALT stop.
module instr_fetch #(
  parameter int          ADDR_W  = 6,
  parameter int          DATA_W  = 16,
  parameter int          MEM_LAT = 1,
  parameter int          QDEPTH  = 2,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic         clock,
  input  logic         reset_n,
  instr_fetch_if.master bus
);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int OW = $clog2(QDEPTH + MEM_LAT + 1) + 1;

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     count, count_n;
  logic [DATA_W-1:0] q_data   [QDEPTH];
  logic [DATA_W-1:0] q_data_n [QDEPTH];
  logic [ADDR_W-1:0] q_pc     [QDEPTH];
  logic [ADDR_W-1:0] q_pc_n   [QDEPTH];
  logic [MEM_LAT-1:0] pipe_v;
  logic [ADDR_W-1:0] pipe_pc  [MEM_LAT];
  logic              pop, push, halt_push, issue;
  logic [OW-1:0]     inflight, occupancy;
  logic [CW-1:0]     wr_idx;

  assign pop       = (count != '0) && bus.instr_ready;
  assign push      = pipe_v[MEM_LAT-1] && !bus.redirect;
  assign halt_push = push && (state == RUN) && (bus.imem_rdata[DATA_W-1 -: 4] == HALT_OP);
  assign wr_idx    = count - CW'(pop);

  // Credit rule: queued words plus outstanding reads must leave room for the new one.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) inflight = inflight + OW'(pipe_v[i]);
    occupancy = OW'(count) + inflight - OW'(pop);
    issue = (state == RUN) && !bus.redirect && !halt_push && (occupancy < OW'(QDEPTH));
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = RUN;
      RUN:     if (!bus.redirect && halt_push) state_n = HALTED;
      HALTED:  if (bus.redirect) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Read pipe; a HALT word also kills the reads issued behind it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_v <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipe_pc[i] <= '0;
    end else begin
      if (bus.redirect || halt_push) begin
        pipe_v <= '0;
      end else begin
        pipe_v[0] <= issue;
        for (int i = 1; i < MEM_LAT; i++) pipe_v[i] <= pipe_v[i-1];
      end
      pipe_pc[0] <= bus.pc_in;
      for (int i = 1; i < MEM_LAT; i++) pipe_pc[i] <= pipe_pc[i-1];
    end
  end

  always_comb begin
    count_n = count;
    for (int i = 0; i < QDEPTH; i++) begin
      q_data_n[i] = q_data[i];
      q_pc_n[i]   = q_pc[i];
    end
    if (bus.redirect) begin
      count_n = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < QDEPTH - 1; i++) begin
          q_data_n[i] = q_data[i+1];
          q_pc_n[i]   = q_pc[i+1];
        end
      end
      if (push) begin
        for (int i = 0; i < QDEPTH; i++) begin
          if (wr_idx == CW'(i)) begin
            q_data_n[i] = bus.imem_rdata;
            q_pc_n[i]   = pipe_pc[MEM_LAT-1];
          end
        end
      end
      count_n = count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      count <= count_n;
      for (int i = 0; i < QDEPTH; i++) begin
        q_data[i] <= q_data_n[i];
        q_pc[i]   <= q_pc_n[i];
      end
    end
  end

  always_comb begin
    if (!reset_n)          bus.pc_next = '0;
    else if (bus.redirect) bus.pc_next = bus.redirect_addr;
    else if (issue)        bus.pc_next = bus.pc_in + ADDR_W'(1);
    else                   bus.pc_next = bus.pc_in;
  end

  assign bus.imem_req    = issue;
  assign bus.imem_addr   = bus.pc_in;
  assign bus.instr       = q_data[0];
  assign bus.instr_pc    = q_pc[0];
  assign bus.instr_valid = (count != '0);
  assign bus.halted      = (state == HALTED);
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench: two fetch instances (1-cycle/2-entry and 3-cycle/4-entry) share stimulus,
// each closing its own PC register and imem model; delivered words are logged and checked.
module tb_instr_fetch;
  logic       clock = 1'b0;
  logic       reset_n;
  logic       ready;
  logic       redirect;
  logic [5:0] redirect_addr;
  logic [15:0] mem [64];
  logic [5:0] pc_a, pc_b;
  logic [15:0] rd_a, s1_b, s2_b, s3_b;
  logic [5:0]  pcs_a [$];
  logic [15:0] ins_a [$];
  logic [5:0]  pcs_b [$];
  logic [15:0] ins_b [$];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  instr_fetch_if #(.ADDR_W(6), .DATA_W(16)) a_if ();
  instr_fetch_if #(.ADDR_W(6), .DATA_W(16)) b_if ();

  instr_fetch #(.ADDR_W(6), .DATA_W(16), .MEM_LAT(1), .QDEPTH(2), .HALT_OP(4'hF)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(a_if));
  instr_fetch #(.ADDR_W(6), .DATA_W(16), .MEM_LAT(3), .QDEPTH(4), .HALT_OP(4'hF)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(b_if));

  assign a_if.pc_in = pc_a;
  assign a_if.redirect = redirect;
  assign a_if.redirect_addr = redirect_addr;
  assign a_if.instr_ready = ready;
  assign a_if.imem_rdata = rd_a;
  assign b_if.pc_in = pc_b;
  assign b_if.redirect = redirect;
  assign b_if.redirect_addr = redirect_addr;
  assign b_if.instr_ready = ready;
  assign b_if.imem_rdata = s3_b;

  // PC registers closing the loop
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_a <= '0;
      pc_b <= '0;
    end else begin
      pc_a <= a_if.pc_next;
      pc_b <= b_if.pc_next;
    end
  end

  // Fixed-latency memories: 1 cycle for a, 3 cycles for b
  always_ff @(posedge clock) begin
    rd_a <= mem[a_if.imem_addr];
    s1_b <= mem[b_if.imem_addr];
    s2_b <= s1_b;
    s3_b <= s2_b;
  end

  always @(negedge clock) begin
    if (reset_n && ready && !redirect) begin
      if (a_if.instr_valid) begin
        pcs_a.push_back(a_if.instr_pc);
        ins_a.push_back(a_if.instr);
      end
      if (b_if.instr_valid) begin
        pcs_b.push_back(b_if.instr_pc);
        ins_b.push_back(b_if.instr);
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_seq(input string tag, input bit use_b, input int base, input logic [5:0] start, input int n);
    int bad;
    int sz;
    logic [5:0] pc;
    logic [5:0] got_pc;
    logic [15:0] got_ins;
    bad = 0;
    pc = start;
    sz = use_b ? pcs_b.size() : pcs_a.size();
    for (int i = 0; i < n; i++) begin
      if (base + i >= sz) begin
        bad++;
      end else begin
        got_pc  = use_b ? pcs_b[base+i] : pcs_a[base+i];
        got_ins = use_b ? ins_b[base+i] : ins_a[base+i];
        if (got_pc !== pc || got_ins !== mem[pc]) bad++;
      end
      pc = pc + 6'd1;
    end
    check_output(tag, bad, 0);
  endtask

  task automatic apply_stimulus(input logic rdy, input logic redir, input logic [5:0] addr);
    @(posedge clock);
    #1;
    ready = rdy;
    redirect = redir;
    redirect_addr = addr;
  endtask

  initial begin
    int base_a, base_b, sz;
    logic [15:0] held_instr;
    logic [5:0]  held_pc, held_pcreg;
    reset_n = 1'b0;
    ready = 1'b0;
    redirect = 1'b0;
    redirect_addr = '0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);

    #12;
    check_output("rst_valid", a_if.instr_valid, 0);
    check_output("rst_req", a_if.imem_req, 0);
    check_output("rst_halted", a_if.halted, 0);
    check_output("rst_pc_next", a_if.pc_next, 0);
    check_output("rst_instr", a_if.instr, 0);
    check_output("rst_instr_pc", a_if.instr_pc, 0);
    check_output("rst_b_valid", b_if.instr_valid, 0);
    check_output("rst_b_req", b_if.imem_req, 0);

    // Release reset with decode always ready
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    ready = 1'b1;
    @(negedge clock);
    check_output("idle_no_issue", a_if.imem_req, 0);
    @(negedge clock);
    check_output("first_issue", a_if.imem_req, 1);
    check_output("first_addr", a_if.imem_addr, 0);
    check_output("first_pc_next", a_if.pc_next, 1);
    @(negedge clock);
    check_output("fill_not_valid", a_if.instr_valid, 0);
    @(negedge clock);
    check_output("head_valid", a_if.instr_valid, 1);
    check_output("head_pc0", a_if.instr_pc, 0);
    check_output("head_instr0", a_if.instr, 16'h1000);
    @(negedge clock);
    check_output("head_pc1", a_if.instr_pc, 1);
    #1;
    base_a = pcs_a.size();
    base_b = pcs_b.size();
    repeat (8) @(negedge clock);
    #1;
    check_output("a_rate", pcs_a.size() - base_a, 8);
    check_output("b_rate", pcs_b.size() - base_b, 8);
    check_seq("a_seq_start", 0, 0, 6'd0, 10);
    check_seq("b_seq_start", 1, 0, 6'd0, 8);

    // Decode stall
    apply_stimulus(1'b0, 1'b0, 6'd0);
    @(negedge clock);
    held_instr = a_if.instr;
    held_pc = a_if.instr_pc;
    @(negedge clock);
    held_pcreg = pc_a;
    repeat (4) @(negedge clock);
    check_output("stall_valid", a_if.instr_valid, 1);
    check_output("stall_req", a_if.imem_req, 0);
    check_output("stall_pc_next", a_if.pc_next, pc_a);
    check_output("stall_pc_held", pc_a, held_pcreg);
    check_output("stall_instr", a_if.instr, held_instr);
    check_output("stall_instr_pc", a_if.instr_pc, held_pc);
    check_output("stall_b_req", b_if.imem_req, 0);
    check_output("stall_b_pc_next", b_if.pc_next, pc_b);
    apply_stimulus(1'b1, 1'b0, 6'd0);
    repeat (10) @(negedge clock);
    #1;
    sz = pcs_a.size();
    check_seq("a_stall_order", 0, 0, 6'd0, sz);
    sz = pcs_b.size();
    check_seq("b_stall_order", 1, 0, 6'd0, sz);

    // Wrap from 62
    apply_stimulus(1'b1, 1'b1, 6'd62);
    base_a = pcs_a.size();
    base_b = pcs_b.size();
    @(negedge clock);
    check_output("redir_pc_next", a_if.pc_next, 62);
    check_output("redir_no_issue", a_if.imem_req, 0);
    apply_stimulus(1'b1, 1'b0, 6'd0);
    repeat (12) @(negedge clock);
    #1;
    check_seq("a_wrap", 0, base_a, 6'd62, 6);
    check_seq("b_wrap", 1, base_b, 6'd62, 4);

    // Redirect while the queue is full and reads are outstanding
    apply_stimulus(1'b0, 1'b0, 6'd0);
    apply_stimulus(1'b0, 1'b1, 6'h20);
    base_a = pcs_a.size();
    base_b = pcs_b.size();
    apply_stimulus(1'b0, 1'b0, 6'd0);
    @(negedge clock);
    check_output("flush_a_valid", a_if.instr_valid, 0);
    check_output("flush_b_valid", b_if.instr_valid, 0);
    apply_stimulus(1'b1, 1'b0, 6'd0);
    repeat (12) @(negedge clock);
    #1;
    check_seq("a_flush_seq", 0, base_a, 6'h20, 6);
    check_seq("b_flush_seq", 1, base_b, 6'h20, 4);

    // HALT word at address 5
    mem[5] = 16'hF000;
    apply_stimulus(1'b1, 1'b1, 6'd0);
    base_a = pcs_a.size();
    base_b = pcs_b.size();
    apply_stimulus(1'b1, 1'b0, 6'd0);
    repeat (20) @(negedge clock);
    #1;
    check_output("a_halted", a_if.halted, 1);
    check_output("a_halt_req", a_if.imem_req, 0);
    check_output("a_halt_drained", a_if.instr_valid, 0);
    check_output("a_halt_pc_next", a_if.pc_next, pc_a);
    check_output("a_halt_count", pcs_a.size() - base_a, 6);
    check_seq("a_halt_seq", 0, base_a, 6'd0, 6);
    check_output("b_halted", b_if.halted, 1);
    check_output("b_halt_req", b_if.imem_req, 0);
    check_output("b_halt_count", pcs_b.size() - base_b, 6);
    check_seq("b_halt_seq", 1, base_b, 6'd0, 6);

    // Redirect out of HALTED
    apply_stimulus(1'b1, 1'b1, 6'd0);
    base_a = pcs_a.size();
    apply_stimulus(1'b1, 1'b0, 6'd0);
    @(negedge clock);
    check_output("a_unhalt", a_if.halted, 0);
    check_output("b_unhalt", b_if.halted, 0);
    check_output("a_restart_req", a_if.imem_req, 1);
    check_output("a_restart_addr", a_if.imem_addr, 0);
    repeat (4) @(negedge clock);
    #1;
    check_seq("a_restart_seq", 0, base_a, 6'd0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
